// File: rtl/norm_pkg.sv
// Shared definitions for the normalization control stage: shift direction
// encodings, the status flag bundle and the leading-zero width check.
package norm_pkg;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef struct packed {
        logic zero;
        logic underflow;
        logic overflow;
    } norm_flags_t;

    // The all-zero count of an SW-1 bit field is SW-1, so EW must hold clog2(SW).
    function automatic bit lz_width_ok(input int sw, input int ew);
        return ($clog2(sw) <= ew);
    endfunction

    localparam bit NORM_DEFAULT_WIDTH_OK = lz_width_ok(26, 5);

endpackage

// File: rtl/leading_zero_counter.sv
// Leading-zero count of a WIDTH-bit field, MSB first; returns WIDTH when the
// field is all zero, with all_zero flagging that case.
module leading_zero_counter #(
    parameter int WIDTH = 25,
    parameter int EW    = 5
) (
    input  logic [WIDTH-1:0] data,
    output logic [EW-1:0]    lz,
    output logic             all_zero
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        lz       = EW'(WIDTH);
        all_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                lz       = EW'(WIDTH - 1 - i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/norm_shift_ctrl.sv
// Normalization control ahead of the significand barrel shifter, with a
// valid/ready pipeline. NORM_LZ_PIPE_EN adds a register after the LZ count.
module norm_shift_ctrl
    import norm_pkg::*;
#(
    parameter int SW   = 26,
    parameter int EW   = 5,
    parameter int EXPW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [SW-1:0]   Data_i,
    input  logic [EXPW-1:0] Exp_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [SW-1:0]   Data_o,
    output logic [EW-1:0]   Shift_Value_o,
    output logic            FSM_left_right_o,
    output logic [EXPW-1:0] Exp_o,
    output logic            Zero_o,
    output logic            Underflow_o,
    output logic            Overflow_o
);

    if (!lz_width_ok(SW, EW)) begin : g_width_check
        $error("norm_shift_ctrl: EW too narrow for SW");
    end

    logic            load_s2;
    logic            load_m;
    logic            s1_valid;
    logic [SW-1:0]   s1_data;
    logic [EXPW-1:0] s1_exp;
    logic [EW-1:0]   lz;
    logic            all_zero;
    logic            m_valid;
    logic [SW-1:0]   m_data;
    logic [EXPW-1:0] m_exp;
    logic [EW-1:0]   m_lz;
    logic            m_zero;
    norm_flags_t     s2_flags;

    assign load_s2    = !out_valid_o || out_ready_i;
    assign in_ready_o = !s1_valid || load_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_exp   <= '0;
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_data <= Data_i;
                s1_exp  <= Exp_i;
            end
        end
    end

    leading_zero_counter #(.WIDTH(SW-1), .EW(EW)) u_lzc (
        .data     (s1_data[SW-2:0]),
        .lz       (lz),
        .all_zero (all_zero)
    );

`ifdef NORM_LZ_PIPE_EN
    logic            sl_valid;
    logic [SW-1:0]   sl_data;
    logic [EXPW-1:0] sl_exp;
    logic [EW-1:0]   sl_lz;
    logic            sl_zero;

    assign load_m = !sl_valid || load_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_valid <= 1'b0;
            sl_data  <= '0;
            sl_exp   <= '0;
            sl_lz    <= '0;
            sl_zero  <= 1'b0;
        end else if (load_m) begin
            sl_valid <= s1_valid;
            if (s1_valid) begin
                sl_data <= s1_data;
                sl_exp  <= s1_exp;
                sl_lz   <= lz;
                sl_zero <= all_zero;
            end
        end
    end

    assign m_valid = sl_valid;
    assign m_data  = sl_data;
    assign m_exp   = sl_exp;
    assign m_lz    = sl_lz;
    assign m_zero  = sl_zero;
`else
    assign load_m  = load_s2;
    assign m_valid = s1_valid;
    assign m_data  = s1_data;
    assign m_exp   = s1_exp;
    assign m_lz    = lz;
    assign m_zero  = all_zero;
`endif

    logic [EXPW:0]   exp_wide;
    logic [EXPW:0]   exp_inc;
    logic [EXPW:0]   lz_wide;
    logic [EXPW:0]   exp_diff;
    logic [EW-1:0]   nxt_shift;
    logic            nxt_dir;
    logic [EXPW-1:0] nxt_exp;
    norm_flags_t     nxt_flags;

    assign exp_wide = {1'b0, m_exp};
    assign exp_inc  = exp_wide + (EXPW+1)'(1);
    assign lz_wide  = (EXPW+1)'(m_lz);
    assign exp_diff = exp_wide - lz_wide;

    always_comb begin
        nxt_dir   = DIR_LEFT;
        nxt_shift = '0;
        nxt_exp   = '0;
        nxt_flags = '0;
        if (m_data[SW-1]) begin
            nxt_dir   = DIR_RIGHT;
            nxt_shift = EW'(1);
            if (exp_inc >= {1'b0, {EXPW{1'b1}}}) begin
                nxt_exp            = '1;
                nxt_flags.overflow = 1'b1;
            end else begin
                nxt_exp = exp_inc[EXPW-1:0];
            end
        end else if (m_zero) begin
            nxt_flags.zero = 1'b1;
        end else if (lz_wide <= exp_wide) begin
            nxt_shift = m_lz;
            nxt_exp   = exp_diff[EXPW-1:0];
        end else begin
            // Exponent runs out first: only shift down to the denormal boundary.
            nxt_shift           = EW'(m_exp);
            nxt_flags.underflow = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o      <= 1'b0;
            Data_o           <= '0;
            Shift_Value_o    <= '0;
            FSM_left_right_o <= DIR_LEFT;
            Exp_o            <= '0;
            s2_flags         <= '0;
        end else if (load_s2) begin
            out_valid_o <= m_valid;
            if (m_valid) begin
                Data_o           <= m_data;
                Shift_Value_o    <= nxt_shift;
                FSM_left_right_o <= nxt_dir;
                Exp_o            <= nxt_exp;
                s2_flags         <= nxt_flags;
            end
        end
    end

    assign Zero_o      = s2_flags.zero;
    assign Underflow_o = s2_flags.underflow;
    assign Overflow_o  = s2_flags.overflow;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Scoreboard bench for norm_shift_ctrl: directed beats push expected results,
// a negedge monitor pops and compares every transferred output beat.
module tb_norm_shift_ctrl;

    localparam int SW   = 26;
    localparam int EW   = 5;
    localparam int EXPW = 8;
`ifdef NORM_LZ_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [SW-1:0]   Data_i;
    logic [EXPW-1:0] Exp_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [SW-1:0]   Data_o;
    logic [EW-1:0]   Shift_Value_o;
    logic            FSM_left_right_o;
    logic [EXPW-1:0] Exp_o;
    logic            Zero_o;
    logic            Underflow_o;
    logic            Overflow_o;

    always #5 clk = ~clk;

    norm_shift_ctrl #(.SW(SW), .EW(EW), .EXPW(EXPW)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .Data_i           (Data_i),
        .Exp_i            (Exp_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .Data_o           (Data_o),
        .Shift_Value_o    (Shift_Value_o),
        .FSM_left_right_o (FSM_left_right_o),
        .Exp_o            (Exp_o),
        .Zero_o           (Zero_o),
        .Underflow_o      (Underflow_o),
        .Overflow_o       (Overflow_o)
    );

    typedef struct packed {
        logic [SW-1:0]   data;
        logic [EW-1:0]   shift;
        logic            dir;
        logic [EXPW-1:0] exp;
        logic            zero;
        logic            uf;
        logic            of;
    } beat_t;

    beat_t sbq[$];
    beat_t mon_exp;
    beat_t prev_out;
    logic  prev_stall = 1'b0;
    int    total = 0;
    int    bad   = 0;

    function automatic beat_t mk(input logic [SW-1:0] d, input int s, input logic dir,
                                 input int e, input logic z, input logic u, input logic o);
        beat_t b;
        b.data  = d;
        b.shift = EW'(s);
        b.dir   = dir;
        b.exp   = EXPW'(e);
        b.zero  = z;
        b.uf    = u;
        b.of    = o;
        return b;
    endfunction

    function automatic beat_t dut_beat();
        return {Data_o, Shift_Value_o, FSM_left_right_o, Exp_o, Zero_o, Underflow_o, Overflow_o};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: pops on every transfer and checks outputs hold while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {out_valid_o, dut_beat()}, {1'b1, prev_out});
            if (out_valid_o && out_ready_i) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %h want none", dut_beat());
                end else begin
                    mon_exp = sbq.pop_front();
                    chk("beat", dut_beat(), mon_exp);
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_out   = dut_beat();
        end
    end

    task automatic send(input logic [SW-1:0] d, input int e, input beat_t expv);
        logic acc;
        acc        = 1'b0;
        in_valid_i = 1'b1;
        Data_i     = d;
        Exp_i      = EXPW'(e);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
            if (acc) begin
                sbq.push_back(expv);
                break;
            end
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1 within 50 cycles");
        end
        #1 in_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sbq.size() != 0; k++) @(posedge clk);
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {out_valid_o, in_ready_o, dut_beat()},
            {1'b0, 1'b1, mk(0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0)});
    endtask

    localparam int ND = 10;
    logic [SW-1:0] dv [ND] = '{26'h0800000, 26'h2000000, 26'h2000000, 26'h0000001, 26'h0000001,
                               26'h0000000, 26'h2000000, 26'h3FFFFFF, 26'h0000100, 26'h0000100};
    int ev [ND] = '{100, 254, 255, 10, 30, 77, 100, 5, 16, 15};
    beat_t xv [ND];

    initial begin
        xv[0] = mk(dv[0],  1, 1'b1,  99, 0, 0, 0);
        xv[1] = mk(dv[1],  1, 1'b0, 255, 0, 0, 1);
        xv[2] = mk(dv[2],  1, 1'b0, 255, 0, 0, 1);
        xv[3] = mk(dv[3], 10, 1'b1,   0, 0, 1, 0);
        xv[4] = mk(dv[4], 24, 1'b1,   6, 0, 0, 0);
        xv[5] = mk(dv[5],  0, 1'b1,   0, 1, 0, 0);
        xv[6] = mk(dv[6],  1, 1'b0, 101, 0, 0, 0);
        xv[7] = mk(dv[7],  1, 1'b0,   6, 0, 0, 0);
        xv[8] = mk(dv[8], 16, 1'b1,   0, 0, 0, 0);
        xv[9] = mk(dv[9], 15, 1'b1,   0, 0, 1, 0);

        rst         = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        Data_i      = '0;
        Exp_i       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;

        // First beat into an empty pipe: latency counted including the accept edge.
        send(26'h1000000, 100, mk(26'h1000000, 0, 1'b1, 100, 0, 0, 0));
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk($sformatf("latency_edge%0d", k), out_valid_o, (k == LAT));
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < ND; i++) send(dv[i], ev[i], xv[i]);
        drain();
        #1;

        // Five back-to-back beats with the output stalled for four cycles.
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(26'h1000000 >> i, 50, mk(26'h1000000 >> i, i, 1'b1, 50 - i, 0, 0, 0));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready_i = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", {out_valid_o, in_ready_o}, 2'b10);
                repeat (3) @(posedge clk);
                #1 out_ready_i = 1'b1;
            end
        join
        drain();
        #1;

        // Reset in the middle of a stall discards buffered beats.
        out_ready_i = 1'b0;
        send(26'h0400000, 40, mk(26'h0400000, 2, 1'b1, 38, 0, 0, 0));
        send(26'h0200000, 40, mk(26'h0200000, 3, 1'b1, 37, 0, 0, 0));
        @(negedge clk);
        chk("pre_reset_valid", out_valid_o, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_stall_reset");
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready_i = 1'b1;
        send(26'h0100000, 60, mk(26'h0100000, 4, 1'b1, 56, 0, 0, 0));
        drain();
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
